// File: rtl/lsu_pkg.sv
// Shared op codes, widths, FSM encoding and alignment helper for the load/store unit.
package lsu_pkg;

    localparam int unsigned LSU_OP_W   = 3;
    localparam int unsigned LSU_ADDR_W = 32;
    localparam int unsigned LSU_DATA_W = 32;
    localparam int unsigned LSU_RD_W   = 5;

    localparam logic [LSU_OP_W-1:0] OP_LB  = 3'd0;
    localparam logic [LSU_OP_W-1:0] OP_LBU = 3'd1;
    localparam logic [LSU_OP_W-1:0] OP_LH  = 3'd2;
    localparam logic [LSU_OP_W-1:0] OP_LHU = 3'd3;
    localparam logic [LSU_OP_W-1:0] OP_LW  = 3'd4;
    localparam logic [LSU_OP_W-1:0] OP_SB  = 3'd5;
    localparam logic [LSU_OP_W-1:0] OP_SH  = 3'd6;
    localparam logic [LSU_OP_W-1:0] OP_SW  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ST_WR  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_t;

    // Halfword ops need addr[0]==0, word ops need addr[1:0]==0.
    function automatic logic is_misaligned(input logic [LSU_OP_W-1:0] op,
                                           input logic [1:0]          off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return off != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [LSU_OP_W-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte lane logic: load extract/extend and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [LSU_DATA_W-1:0] load_word,
    input  logic [LSU_DATA_W-1:0] store_old,
    input  logic [LSU_DATA_W-1:0] store_wdata,
    input  logic [1:0]            byte_off,
    input  logic [LSU_OP_W-1:0]   op,
    output logic [LSU_DATA_W-1:0] load_data_c,
    output logic [LSU_DATA_W-1:0] store_word_c
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign load_byte = load_word[{byte_off, 3'b000} +: 8];
    assign load_half = load_word[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        load_data_c = load_word;
        case (op)
            OP_LB:   load_data_c = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_data_c = {24'h0, load_byte};
            OP_LH:   load_data_c = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_data_c = {16'h0, load_half};
            default: load_data_c = load_word;
        endcase
    end

    // Replace only the addressed lane; SW passes the store data straight through.
    always_comb begin
        store_word_c = store_old;
        case (op)
            OP_SB:   store_word_c[{byte_off, 3'b000} +: 8]     = store_wdata[7:0];
            OP_SH:   store_word_c[{byte_off[1], 4'b0000} +: 16] = store_wdata[15:0];
            default: store_word_c = store_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end over a word-only data memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W,
    parameter int unsigned DATA_W = LSU_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [LSU_OP_W-1:0] req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [LSU_RD_W-1:0] req_rd,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic [LSU_RD_W-1:0] resp_rd,
    output logic                misalign_exc,
    output logic [ADDR_W-1:0]   bad_addr,
    output logic [ADDR_W-1:0]   mem_access_addr,
    output logic [DATA_W-1:0]   mem_write_data,
    output logic                mem_write_en,
    output logic                mem_read,
    input  logic [DATA_W-1:0]   mem_read_data
);

    lsu_state_t            state;
    lsu_state_t            state_nxt;
    logic [LSU_OP_W-1:0]   op_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     merge_q;
    logic [LSU_RD_W-1:0]   rd_q;
    logic                  accept_c;
    logic                  misalign_c;
    logic [ADDR_W-1:0]     word_addr_c;
    logic [DATA_W-1:0]     load_data_c;
    logic [DATA_W-1:0]     store_word_c;

    assign req_ready   = (state == ST_IDLE) && rst;
    assign accept_c    = req_valid && req_ready;
    assign misalign_c  = is_misaligned(req_op, req_addr[1:0]);
    assign word_addr_c = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_align u_align (
        .load_word    (mem_read_data),
        .store_old    (merge_q),
        .store_wdata  (wdata_q),
        .byte_off     (addr_q[1:0]),
        .op           (op_q),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory port is decoded from state and latched request only.
    always_comb begin
        state_nxt       = state;
        mem_read        = 1'b0;
        mem_write_en    = 1'b0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        case (state)
            ST_IDLE: begin
                if (accept_c && !misalign_c) begin
                    if (req_op == OP_SW) begin
                        state_nxt = ST_ST_WR;
                    end else if (is_store(req_op)) begin
                        state_nxt = ST_RMW_RD;
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                mem_read        = 1'b1;
                mem_access_addr = word_addr_c;
                state_nxt       = ST_RESP;
            end
            ST_ST_WR: begin
                mem_write_en    = 1'b1;
                mem_access_addr = word_addr_c;
                mem_write_data  = wdata_q;
                state_nxt       = ST_IDLE;
            end
            ST_RMW_RD: begin
                mem_read        = 1'b1;
                mem_access_addr = word_addr_c;
                state_nxt       = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_write_en    = 1'b1;
                mem_access_addr = word_addr_c;
                mem_write_data  = store_word_c;
                state_nxt       = ST_IDLE;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // A reset landing mid read-modify-write must never emit a partial word.
        if (!rst) begin
            mem_read     = 1'b0;
            mem_write_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            merge_q      <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_rd      <= '0;
            misalign_exc <= 1'b0;
            bad_addr     <= '0;
        end else begin
            resp_valid   <= (state == ST_LOAD);
            misalign_exc <= accept_c && misalign_c;
            if (accept_c && misalign_c) begin
                bad_addr <= req_addr;
            end
            if (accept_c && !misalign_c) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
            end
            if (state == ST_LOAD) begin
                resp_data <= load_data_c;
                resp_rd   <= rd_q;
            end
            if (state == ST_RMW_RD) begin
                merge_q <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: byte-array memory model drives expectations for directed and random traffic.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        misalign_exc;
    logic [31:0] bad_addr;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [31:0] mem_read_data;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int n_resps  = 0;

    logic [31:0] mem       [0:31];
    logic [7:0]  ref_bytes [0:127];

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_rd         (resp_rd),
        .misalign_exc    (misalign_exc),
        .bad_addr        (bad_addr),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    // Word-wide data memory seen by the DUT.
    assign mem_read_data = mem[mem_access_addr[6:2]];
    always @(posedge clk) begin
        if (mem_write_en === 1'b1) begin
            mem[mem_access_addr[6:2]] <= mem_write_data;
            n_writes <= n_writes + 1;
        end
    end
    always @(negedge clk) if (resp_valid === 1'b1) n_resps <= n_resps + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int access_size(input logic [2:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 1;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] op, input int a);
        return (a % access_size(op)) != 0;
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & ~3;
        return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input int a);
        logic [7:0]  b;
        logic [15:0] h;
        b = ref_bytes[a];
        h = {ref_bytes[a | 1], ref_bytes[a & ~1]};
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            default: return ref_word(a);
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] op, input int a, input logic [31:0] wd);
        for (int i = 0; i < access_size(op); i++) ref_bytes[a + i] = wd[8*i +: 8];
    endtask

    // Issue one request, check its full cycle sequence, end with the unit idle again.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          output logic [31:0] obs);
        int          a;
        int          waited;
        logic [31:0] exp;
        a         = int'(addr[6:0]);
        obs       = 32'hDEAD_BEEF;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_rd    = rd;
        req_valid = 1'b1;
        waited    = 0;
        while (req_ready !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b want 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        step();
        req_valid = 1'b0;
        if (ref_misaligned(op, a)) begin
            obs = bad_addr;
            n_checks++;
            if (misalign_exc !== 1'b1 || bad_addr !== addr) begin
                n_fail++;
                $display("FAIL misalign_pulse: exc=%b bad_addr=%h want 1 %h", misalign_exc, bad_addr, addr);
            end
            n_checks++;
            if (mem_read !== 1'b0 || mem_write_en !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL misalign_quiet: rd=%b we=%b ready=%b want 0 0 1", mem_read, mem_write_en, req_ready);
            end
            step();
            n_checks++;
            if (misalign_exc !== 1'b0 || mem_read !== 1'b0 || mem_write_en !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign_end: exc=%b rd=%b we=%b want 0 0 0", misalign_exc, mem_read, mem_write_en);
            end
        end else if (op == OP_SW) begin
            obs = mem_write_data;
            n_checks++;
            if (mem_write_en !== 1'b1 || mem_read !== 1'b0 || mem_access_addr !== {addr[31:2], 2'b00}
                || mem_write_data !== wd) begin
                n_fail++;
                $display("FAIL sw_write: we=%b rd=%b addr=%h data=%h want 1 0 %h %h",
                         mem_write_en, mem_read, mem_access_addr, mem_write_data, {addr[31:2], 2'b00}, wd);
            end
            ref_store(op, a, wd);
            step();
            n_checks++;
            if (req_ready !== 1'b1 || mem_write_en !== 1'b0) begin
                n_fail++;
                $display("FAIL sw_done: ready=%b we=%b want 1 0", req_ready, mem_write_en);
            end
        end else if (op == OP_SB || op == OP_SH) begin
            n_checks++;
            if (mem_read !== 1'b1 || mem_write_en !== 1'b0 || mem_access_addr !== {addr[31:2], 2'b00}) begin
                n_fail++;
                $display("FAIL rmw_read: rd=%b we=%b addr=%h want 1 0 %h",
                         mem_read, mem_write_en, mem_access_addr, {addr[31:2], 2'b00});
            end
            ref_store(op, a, wd);
            exp = ref_word(a);
            step();
            obs = mem_write_data;
            n_checks++;
            if (mem_write_en !== 1'b1 || mem_read !== 1'b0 || mem_write_data !== exp
                || mem_access_addr !== {addr[31:2], 2'b00}) begin
                n_fail++;
                $display("FAIL rmw_write: we=%b rd=%b data=%h addr=%h want 1 0 %h %h",
                         mem_write_en, mem_read, mem_write_data, mem_access_addr, exp, {addr[31:2], 2'b00});
            end
            step();
            n_checks++;
            if (req_ready !== 1'b1 || mem_write_en !== 1'b0) begin
                n_fail++;
                $display("FAIL rmw_done: ready=%b we=%b want 1 0", req_ready, mem_write_en);
            end
        end else begin
            exp = ref_load(op, a);
            n_checks++;
            if (mem_read !== 1'b1 || mem_write_en !== 1'b0 || resp_valid !== 1'b0
                || mem_access_addr !== {addr[31:2], 2'b00}) begin
                n_fail++;
                $display("FAIL load_read: rd=%b we=%b rv=%b addr=%h want 1 0 0 %h",
                         mem_read, mem_write_en, resp_valid, mem_access_addr, {addr[31:2], 2'b00});
            end
            step();
            obs = resp_data;
            n_checks++;
            if (resp_valid !== 1'b1 || resp_data !== exp || resp_rd !== rd || mem_read !== 1'b0) begin
                n_fail++;
                $display("FAIL load_resp: rv=%b data=%h rd=%0d mrd=%b want 1 %h %0d 0",
                         resp_valid, resp_data, resp_rd, mem_read, exp, rd);
            end
            step();
            n_checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_done: rv=%b ready=%b want 0 1", resp_valid, req_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'hCAFE_F00D;
        req_rd    = 5'd1;
        repeat (3) step();
        n_checks++;
        if (req_ready !== 1'b0 || mem_write_en !== 1'b0 || mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ports: ready=%b we=%b rd=%b want 0 0 0", req_ready, mem_write_en, mem_read);
        end
        n_checks++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_rd !== 5'd0
            || misalign_exc !== 1'b0 || bad_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: rv=%b data=%h rd=%0d exc=%b bad=%h want all 0",
                     resp_valid, resp_data, resp_rd, misalign_exc, bad_addr);
        end
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || mem_access_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b addr=%h want 1 0", req_ready, mem_access_addr);
        end
        step();
        n_checks++;
        if (mem[4] !== ref_word(16) || n_writes != 0) begin
            n_fail++;
            $display("FAIL reset_ignored_req: word=%h writes=%0d want %h 0", mem[4], n_writes, ref_word(16));
        end
    endtask

    task automatic test_directed();
        logic [31:0] obs;
        do_req(OP_SW, 32'h40, 32'h8899_AABB, 5'd0, obs);
        n_checks++;
        if (obs !== 32'h8899_AABB) begin n_fail++; $display("FAIL dir_sw: got %h want 8899aabb", obs); end
        do_req(OP_LB, 32'h43, 32'h0, 5'd3, obs);
        n_checks++;
        if (obs !== 32'hFFFF_FF88) begin n_fail++; $display("FAIL dir_lb: got %h want ffffff88", obs); end
        do_req(OP_LBU, 32'h43, 32'h0, 5'd4, obs);
        n_checks++;
        if (obs !== 32'h0000_0088) begin n_fail++; $display("FAIL dir_lbu: got %h want 00000088", obs); end
        do_req(OP_LH, 32'h42, 32'h0, 5'd5, obs);
        n_checks++;
        if (obs !== 32'hFFFF_8899) begin n_fail++; $display("FAIL dir_lh: got %h want ffff8899", obs); end
        do_req(OP_LW, 32'h40, 32'h0, 5'd31, obs);
        n_checks++;
        if (obs !== 32'h8899_AABB) begin n_fail++; $display("FAIL dir_lw: got %h want 8899aabb", obs); end
        do_req(OP_SB, 32'h41, 32'h0000_0123, 5'd0, obs);
        n_checks++;
        if (obs !== 32'h8899_23BB) begin n_fail++; $display("FAIL dir_sb: got %h want 889923bb", obs); end
        do_req(OP_SH, 32'h42, 32'h0000_5566, 5'd0, obs);
        n_checks++;
        if (obs !== 32'h5566_23BB) begin n_fail++; $display("FAIL dir_sh: got %h want 556623bb", obs); end
        do_req(OP_LHU, 32'h42, 32'h0, 5'd9, obs);
        n_checks++;
        if (obs !== 32'h0000_5566) begin n_fail++; $display("FAIL dir_lhu: got %h want 00005566", obs); end
    endtask

    task automatic test_misaligned();
        logic [31:0] obs;
        int          w0;
        w0 = n_writes;
        do_req(OP_LH, 32'h41, 32'h0, 5'd2, obs);
        n_checks++;
        if (obs !== 32'h41) begin n_fail++; $display("FAIL mis_lh: bad_addr %h want 00000041", obs); end
        do_req(OP_SW, 32'h46, 32'h1234_5678, 5'd0, obs);
        n_checks++;
        if (obs !== 32'h46) begin n_fail++; $display("FAIL mis_sw: bad_addr %h want 00000046", obs); end
        n_checks++;
        if (n_writes != w0 || mem[17] !== ref_word(68)) begin
            n_fail++;
            $display("FAIL mis_no_write: writes=%0d word=%h want %0d %h", n_writes - w0, mem[17], 0, ref_word(68));
        end
    endtask

    task automatic test_reset_mid_rmw();
        int w0;
        w0        = n_writes;
        req_op    = OP_SB;
        req_addr  = 32'h44;
        req_wdata = 32'h0000_00A5;
        req_rd    = 5'd0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n_checks++;
        if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rmw_rst_read: rd=%b want 1", mem_read); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (mem_read !== 1'b0 || mem_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_rst_forced: rd=%b we=%b want 0 0", mem_read, mem_write_en);
        end
        step();
        n_checks++;
        if (mem_write_en !== 1'b0 || resp_valid !== 1'b0 || misalign_exc !== 1'b0
            || bad_addr !== 32'h0 || resp_data !== 32'h0 || mem_access_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rmw_rst_outputs: we=%b rv=%b exc=%b bad=%h data=%h addr=%h want all 0",
                     mem_write_en, resp_valid, misalign_exc, bad_addr, resp_data, mem_access_addr);
        end
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_rst_ready: ready=%b want 1", req_ready); end
        step();
        n_checks++;
        if (n_writes != w0 || mem[17] !== ref_word(68) || mem_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_rst_mem: writes=%0d word=%h we=%b want 0 %h 0", n_writes - w0, mem[17], mem_write_en, ref_word(68));
        end
    endtask

    task automatic test_back_to_back();
        int          w0;
        int          r0;
        int          waited;
        logic [31:0] exp;
        w0 = n_writes;
        r0 = n_resps;
        // SW then LW of the same word with req_valid held throughout.
        req_op = OP_SW; req_addr = 32'h48; req_wdata = 32'h0BAD_CAFE; req_rd = 5'd0;
        req_valid = 1'b1;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 8) begin step(); waited++; end
        step();
        ref_store(OP_SW, 72, 32'h0BAD_CAFE);
        n_checks++;
        if (mem_write_en !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_sw_busy: we=%b ready=%b want 1 0", mem_write_en, req_ready);
        end
        req_op = OP_LW; req_addr = 32'h48; req_wdata = 32'h0; req_rd = 5'd7;
        step();
        n_checks++;
        if (req_ready !== 1'b1 || mem_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_sw_idle: ready=%b we=%b want 1 0", req_ready, mem_write_en);
        end
        step();
        req_valid = 1'b0;
        n_checks++;
        if (mem_read !== 1'b1 || mem_access_addr !== 32'h48) begin
            n_fail++;
            $display("FAIL b2b_lw_read: rd=%b addr=%h want 1 00000048", mem_read, mem_access_addr);
        end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h0BAD_CAFE || resp_rd !== 5'd7) begin
            n_fail++;
            $display("FAIL b2b_lw_resp: rv=%b data=%h rd=%0d want 1 0badcafe 7", resp_valid, resp_data, resp_rd);
        end
        // LBU then SB with the SB pending through the response cycle.
        step();
        req_op = OP_LBU; req_addr = 32'h49; req_rd = 5'd3; req_valid = 1'b1;
        exp = ref_load(OP_LBU, 73);
        step();
        req_op = OP_SB; req_addr = 32'h4A; req_wdata = 32'h0000_00EE; req_rd = 5'd0;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_lbu_busy: ready=%b want 0", req_ready); end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_data !== exp || resp_rd !== 5'd3 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_lbu_resp: rv=%b data=%h rd=%0d ready=%b want 1 %h 3 0", resp_valid, resp_data, resp_rd, req_ready, exp);
        end
        step();
        step();
        req_valid = 1'b0;
        ref_store(OP_SB, 74, 32'h0000_00EE);
        exp = ref_word(72);
        step();
        n_checks++;
        if (mem_write_en !== 1'b1 || mem_write_data !== exp) begin
            n_fail++;
            $display("FAIL b2b_sb_write: we=%b data=%h want 1 %h", mem_write_en, mem_write_data, exp);
        end
        step();
        n_checks++;
        if (n_writes - w0 != 2 || n_resps - r0 != 2 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_counts: writes=%0d resps=%0d ready=%b want 2 2 1", n_writes - w0, n_resps - r0, req_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] obs;
        logic [2:0]  op;
        int          a;
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 127);
            if ($urandom_range(0, 3) != 0) a = a & ~(access_size(op) - 1);
            do_req(op, 32'(a), $urandom, 5'($urandom_range(0, 31)), obs);
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    task automatic test_final_memory();
        for (int w = 0; w < 32; w++) begin
            n_checks++;
            if (mem[w] !== ref_word(4 * w)) begin
                n_fail++;
                $display("FAIL final_mem[%0d]: got %h want %h", w, mem[w], ref_word(4 * w));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_bytes[i] = 8'($urandom);
        for (int w = 0; w < 32; w++) mem[w] = ref_word(4 * w);
        rst       = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_rd    = '0;
        step();
        test_reset();
        test_directed();
        test_misaligned();
        test_reset_mid_rmw();
        test_back_to_back();
        test_random();
        test_final_memory();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage front end that sits directly upstream of the word-wide data memory and drives its address, data, write-enable and read ports.
- Accepts one load/store request at a time from the EX/MEM pipeline register.
- Performs byte and halfword stores as read-modify-write over the word-only memory, and sign- or zero-extends load results.
- Flags misaligned accesses. Back-pressure to the pipeline is via req_ready.

Parameters:
- ADDR_W, 32, byte address width of requests and memory port
- DATA_W, 32, data width; fixed at 32, not meant to be overridden

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  unit idle; request accepted when req_valid && req_ready
- req_op  input  3  operation code (package constants)
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low byte/halfword used for SB/SH
- req_rd  input  5  destination register tag for loads
- resp_valid  output  1  one-cycle pulse, load result valid
- resp_data  output  32  extended load result
- resp_rd  output  5  tag echoed with resp_valid
- misalign_exc  output  1  one-cycle pulse on rejected misaligned request
- bad_addr  output  32  address of last misaligned request, held
- mem_access_addr  output  32  word-aligned byte address to data memory
- mem_write_data  output  32  full word to write
- mem_write_en  output  1  write strobe, one cycle per store
- mem_read  output  1  read enable
- mem_read_data  input  32  combinational read data from data memory

Behaviour:
- Byte order: little-endian; byte k of a word is bits [8k+7:8k].
- mem_access_addr = {addr[31:2],2'b00} of the latched request.
- Op codes: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
- States: IDLE, LOAD, ST_WR, RMW_RD, RMW_WR, RESP. req_ready = (state==IDLE) && rst.
- Acceptance in cycle T latches op, addr, wdata and rd, then branches:
  - loads -> LOAD
  - SW -> ST_WR
  - SB/SH -> RMW_RD
- Misaligned request, checked at acceptance:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - misalign_exc=1 in T+1 and bad_addr<=req_addr.
  - State stays IDLE; no mem_read or mem_write_en at any time.
- LOAD (T+1):
  - mem_read=1; mem_read_data is extracted by addr[1:0] and extended per op, then registered.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW uses the full word.
  - -> RESP.
- RESP (T+2): resp_valid=1 with resp_data and resp_rd; -> IDLE. Next request can be accepted in T+3.
- ST_WR (T+1): mem_write_en=1, mem_write_data=wdata; -> IDLE. Next acceptance at T+2.
- RMW_RD (T+1): mem_read=1; capture mem_read_data into the merge register; -> RMW_WR.
- RMW_WR (T+2):
  - Write the merged word: only the addressed byte (SB) or halfword (SH) is replaced by the wdata low bits.
  - mem_write_en=1; -> IDLE.
- mem_read, mem_write_en and mem_access_addr are 0 in IDLE and RESP.
- Outputs are decoded from state plus registers; no combinational path from req_* to mem_*.
- Reset (rst=0 at a clock edge):
  - state<=IDLE.
  - resp_valid, resp_data, resp_rd, misalign_exc and bad_addr <= 0.
  - Internal latches are cleared.
- While rst=0, mem_write_en and mem_read are forced 0 combinationally, so a reset mid-RMW never writes a partial word.
- Requests presented while rst=0 are ignored.
- req_valid held while busy: the request stays pending and is accepted on the first cycle req_ready=1. Only one transaction is ever in flight.

Decomposition:
- Package lsu_pkg holds:
  - op code constants and width LSU_OP_W=3
  - state encoding
  - function is_misaligned(op, addr[1:0])
- Natural sub-module: lsu_align, purely combinational. It contains:
  - load extract/extend: word, addr[1:0], op -> result
  - store merge: old word, wdata, addr[1:0], op -> new word

Test Plan:
- SW addr 0x40 wdata 0x8899AABB at T -> T+1: mem_write_en=1, mem_access_addr=0x40, mem_write_data=0x8899AABB; req_ready=1 at T+2.
- After that store, LB 0x43 -> resp_valid at T+2 with resp_data=0xFFFFFF88; LBU 0x43 -> 0x00000088; LH 0x42 -> 0xFFFF8899; LW 0x40 -> 0x8899AABB; resp_rd echoes the tag.
- SB 0x41 wdata 0x00000123 -> T+1 mem_read=1; T+2 mem_write_en=1 with data 0x889923BB; SH 0x42 wdata 0x5566 -> 0x556623BB.
- LH 0x41 -> misalign_exc pulse at T+1, bad_addr=0x41, mem_read and mem_write_en stay 0; SW 0x46 behaves the same.
- SB issued, rst=0 on the RMW_RD cycle -> no mem_write_en asserted, memory word unchanged, state IDLE; all outputs 0 after the edge, req_ready=1 once rst=1.
- req_valid held high with two different requests back-to-back -> second accepted only when req_ready=1; no request lost or duplicated.
